// File: rtl/core_pkg.sv
// Shared MEM-stage types: control bundle, access sizes, funct3 codes and FSM states.
// Helpers decode access size and evaluate conditional-branch outcomes.
package core_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_e;
  typedef enum logic {IDLE, REQ} mem_state_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [2:0] funct3;
  } mem_ctrl_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Doubleword encodings fall back to word width on a 32-bit datapath.
  function automatic mem_size_e f3_size(input logic [2:0] f3, input int xlen);
    if (f3[1:0] == 2'b11 && xlen < 64) return SZ_W;
    return mem_size_e'(f3[1:0]);
  endfunction

  function automatic logic [3:0] size_bytes(input mem_size_e s);
    case (s)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic branch_cond(input logic [2:0] f3, input logic zero,
                                       input logic lt, input logic ltu);
    case (f3)
      F3_BEQ:  return zero;
      F3_BNE:  return ~zero;
      F3_BLT:  return lt;
      F3_BGE:  return ~lt;
      F3_BLTU: return ltu;
      F3_BGEU: return ~ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: places store data/byte enables at the addressed lane
// and extracts/extends load data from it.
module mem_lane_align
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB  = XLEN / 8,
  localparam int LGB = $clog2(NB)
) (
  input  logic [LGB-1:0]  lane_i,
  input  mem_size_e       size_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [NB-1:0]   be_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [7:0]      mask8;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] tmp;
  int              bits;
  int              left;

  always_comb begin
    mask8 = 8'h00;
    bits  = 8;
    case (size_i)
      SZ_B:    begin mask8 = 8'h01; bits = 8;  end
      SZ_H:    begin mask8 = 8'h03; bits = 16; end
      SZ_W:    begin mask8 = 8'h0f; bits = 32; end
      default: begin mask8 = 8'hff; bits = 64; end
    endcase
    if (bits > XLEN) bits = XLEN;
    left = XLEN - bits;

    wdata_o = wdata_i << (8 * lane_i);
    be_o    = mask8[NB-1:0] << lane_i;

    // Move the addressed field to the top, then shift back down to extend it.
    sh      = rdata_i >> (8 * lane_i);
    tmp     = sh << left;
    rdata_o = unsigned_i ? (tmp >> left) : $unsigned($signed(tmp) >>> left);
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: drives a variable-latency data-memory port, stalls the pipe
// while an access is outstanding, and registers load data, traps and PC redirect.
module mem_stage_ctrl
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16,
  localparam int NB     = XLEN / 8,
  localparam int LGB    = $clog2(NB),
  localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [XLEN-1:0]   i_wrData,
  input  mem_ctrl_t         i_ctrlMEM,
  input  logic              i_zero,
  input  logic              i_lt,
  input  logic              i_ltu,
  output logic              o_stall,
  output logic              o_valid,
  output logic [XLEN-1:0]   o_readData,
  output logic              o_PCSrc,
  output logic              o_excMisalign,
  output logic              o_excBus,
  output logic              o_memReq,
  output logic              o_memWe,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [XLEN-1:0]   o_memWdata,
  output logic [NB-1:0]     o_memBe,
  input  logic              i_memReady,
  input  logic [XLEN-1:0]   i_memRdata,
  output mem_state_e        o_dbgState
);

  mem_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            pcsrc_q, pcsrc_d;
  logic            exm_q, exm_d;
  logic            exb_q, exb_d;

  logic            mem_op;
  logic            misalign;
  logic            pcsrc_new;
  mem_size_e       size;
  logic [LGB-1:0]  lane;
  logic [LGB-1:0]  align_mask;
  logic [XLEN-1:0] load_ext;
  logic [NB-1:0]   be;

  assign mem_op     = i_ctrlMEM.mem_read | i_ctrlMEM.mem_write;
  assign size       = f3_size(i_ctrlMEM.funct3, XLEN);
  assign lane       = i_addr[LGB-1:0];
  assign align_mask = LGB'(size_bytes(size) - 4'd1);
  assign misalign   = |(lane & align_mask);
  assign pcsrc_new  = (i_ctrlMEM.branch &
                       branch_cond(i_ctrlMEM.funct3, i_zero, i_lt, i_ltu)) | i_ctrlMEM.jump;

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .lane_i     (lane),
    .size_i     (size),
    .unsigned_i (i_ctrlMEM.funct3[2]),
    .wdata_i    (i_wrData),
    .rdata_i    (i_memRdata),
    .wdata_o    (o_memWdata),
    .be_o       (be),
    .rdata_o    (load_ext)
  );

  // Handshake: an access completes in the cycle o_memReq & i_memReady are both high;
  // o_memReq stays high with stable addr/we/be/wdata until then, and the upstream
  // holds i_valid and the instruction stable for as long as o_stall is high.
  assign o_memReq   = (state_q == REQ);
  assign o_memWe    = o_memReq & i_ctrlMEM.mem_write;
  assign o_memBe    = o_memReq ? be : '0;
  assign o_memAddr  = {i_addr[ADDR_W-1:LGB], {LGB{1'b0}}};
  assign o_dbgState = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    rdata_d = rdata_q;
    pcsrc_d = pcsrc_q;
    exm_d   = exm_q;
    exb_d   = exb_q;
    o_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (!mem_op) begin
            valid_d = 1'b1;
            rdata_d = '0;
            pcsrc_d = pcsrc_new;
            exm_d   = 1'b0;
            exb_d   = 1'b0;
          end else if (misalign) begin
            valid_d = 1'b1;
            rdata_d = '0;
            pcsrc_d = 1'b0;
            exm_d   = 1'b1;
            exb_d   = 1'b0;
          end else begin
            o_stall = 1'b1;
            state_d = REQ;
            cnt_d   = '0;
          end
        end
      end
      REQ: begin
        if (i_memReady) begin
          valid_d = 1'b1;
          rdata_d = i_ctrlMEM.mem_read ? load_ext : '0;
          pcsrc_d = pcsrc_new;
          exm_d   = 1'b0;
          exb_d   = 1'b0;
          state_d = IDLE;
        end else begin
          o_stall = 1'b1;
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            valid_d = 1'b1;
            rdata_d = '0;
            pcsrc_d = 1'b0;
            exm_d   = 1'b0;
            exb_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      pcsrc_q <= 1'b0;
      exm_q   <= 1'b0;
      exb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      pcsrc_q <= pcsrc_d;
      exm_q   <= exm_d;
      exb_q   <= exb_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_readData    = rdata_q;
  assign o_PCSrc       = pcsrc_q;
  assign o_excMisalign = exm_q;
  assign o_excBus      = exb_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: driver tasks push expected results into a queue,
// a negedge monitor pops and compares on every o_valid pulse.
module tb_mem_stage_ctrl;
  import core_pkg::*;

  localparam int XLEN    = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int W       = 35;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_valid = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [XLEN-1:0]   i_wrData = '0;
  mem_ctrl_t         i_ctrlMEM = '0;
  logic              i_zero = 1'b0;
  logic              i_lt = 1'b0;
  logic              i_ltu = 1'b0;
  logic              i_memReady = 1'b0;
  logic [XLEN-1:0]   i_memRdata = '0;
  logic              o_stall, o_valid, o_PCSrc, o_excMisalign, o_excBus;
  logic              o_memReq, o_memWe;
  logic [XLEN-1:0]   o_readData, o_memWdata;
  logic [ADDR_W-1:0] o_memAddr;
  logic [3:0]        o_memBe;
  mem_state_e        o_dbgState;

  mem_stage_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_addr(i_addr),
    .i_wrData(i_wrData), .i_ctrlMEM(i_ctrlMEM), .i_zero(i_zero), .i_lt(i_lt),
    .i_ltu(i_ltu), .o_stall(o_stall), .o_valid(o_valid), .o_readData(o_readData),
    .o_PCSrc(o_PCSrc), .o_excMisalign(o_excMisalign), .o_excBus(o_excBus),
    .o_memReq(o_memReq), .o_memWe(o_memWe), .o_memAddr(o_memAddr),
    .o_memWdata(o_memWdata), .o_memBe(o_memBe), .i_memReady(i_memReady),
    .i_memRdata(i_memRdata), .o_dbgState(o_dbgState)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           stall_c, req_c;
  logic [31:0]  cap_addr, cap_wdata;
  logic [3:0]   cap_be;
  logic         cap_we;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic mem_ctrl_t mk(input logic rd, input logic wr, input logic br,
                                   input logic jp, input logic [2:0] f3);
    mem_ctrl_t c;
    c.mem_read  = rd;
    c.mem_write = wr;
    c.branch    = br;
    c.jump      = jp;
    c.funct3    = f3;
    return c;
  endfunction

  function automatic logic [W-1:0] pk(input logic pc, input logic em, input logic eb,
                                      input logic [31:0] rd);
    return {pc, em, eb, rd};
  endfunction

  // driver: issue one instruction, play memory with wait_n not-ready REQ cycles
  task automatic run(input mem_ctrl_t c, input logic [31:0] addr, input logic [31:0] wd,
                     input logic z, input logic l, input logic lu, input int wait_n,
                     input logic [31:0] rdata, input logic [W-1:0] exp);
    @(posedge i_clk); #1;
    i_ctrlMEM  = c;
    i_addr     = addr;
    i_wrData   = wd;
    i_zero     = z;
    i_lt       = l;
    i_ltu      = lu;
    i_memReady = 1'b0;
    i_valid    = 1'b1;
    exp_q.push_back(exp);
    stall_c = 0;
    req_c   = 0;
    @(negedge i_clk);
    if (o_stall) stall_c++;
    check("req_in_idle", o_memReq, 0);
    for (int k = 0; k < 40; k++) begin
      @(posedge i_clk); #1;
      if (!o_memReq) break;
      req_c++;
      i_memReady = (k == wait_n);
      i_memRdata = rdata;
      @(negedge i_clk);
      if (o_stall) stall_c++;
      if (req_c == 1) begin
        cap_addr  = o_memAddr;
        cap_wdata = o_memWdata;
        cap_be    = o_memBe;
        cap_we    = o_memWe;
      end
    end
    check("valid_pulse", o_valid, 1);
    check("req_dropped", o_memReq, 0);
    i_valid    = 1'b0;
    i_memReady = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge i_clk) begin
    if (!i_reset && o_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid: got {pc,exm,exb,rd}=0x%0h with no expectation",
                 {o_PCSrc, o_excMisalign, o_excBus, o_readData});
      end else begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        e = exp_q.pop_front();
        a = {o_PCSrc, o_excMisalign, o_excBus, o_readData};
        if (a !== e) begin
          n_bad++;
          $display("FAIL result: got {pc,exm,exb,rd}=0x%0h, expected 0x%0h", a, e);
        end
      end
    end
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish, %0d mismatched so far", n_bad);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge i_clk);
    check("rst_valid", o_valid, 0);
    check("rst_rdata", o_readData, 0);
    check("rst_pcsrc", o_PCSrc, 0);
    check("rst_exc", {o_excMisalign, o_excBus}, 0);
    check("rst_memreq", o_memReq, 0);
    check("rst_state", o_dbgState, IDLE);
    @(posedge i_clk); #1;
    i_reset = 1'b0;

    // LW, ready on first REQ cycle
    run(mk(1, 0, 0, 0, F3_LW), 32'h100, 0, 0, 0, 0, 0, 32'hDEADBEEF,
        pk(0, 0, 0, 32'hDEADBEEF));
    check("lw_stall", stall_c, 1);
    check("lw_reqc", req_c, 1);
    check("lw_addr", cap_addr, 32'h100);
    check("lw_be", cap_be, 4'b1111);
    check("lw_we", cap_we, 0);

    // byte loads at lane 3
    run(mk(1, 0, 0, 0, F3_LB), 32'h103, 0, 0, 0, 0, 0, 32'h80123456,
        pk(0, 0, 0, 32'hFFFFFF80));
    check("lb_be", cap_be, 4'b1000);
    check("lb_addr", cap_addr, 32'h100);
    run(mk(1, 0, 0, 0, F3_LBU), 32'h103, 0, 0, 0, 0, 1, 32'h80123456,
        pk(0, 0, 0, 32'h00000080));
    check("lbu_stall", stall_c, 2);

    // halfword loads at lane 2
    run(mk(1, 0, 0, 0, F3_LH), 32'h102, 0, 0, 0, 0, 0, 32'hBEEF0000,
        pk(0, 0, 0, 32'hFFFFBEEF));
    run(mk(1, 0, 0, 0, F3_LHU), 32'h102, 0, 0, 0, 0, 0, 32'hBEEF0000,
        pk(0, 0, 0, 32'h0000BEEF));

    // SH at 0x102 with two wait cycles
    run(mk(0, 1, 0, 0, 3'b001), 32'h102, 32'h00001234, 0, 0, 0, 2, 32'h0,
        pk(0, 0, 0, 32'h0));
    check("sh_be", cap_be, 4'b1100);
    check("sh_wdata_hi", cap_wdata[31:16], 16'h1234);
    check("sh_addr", cap_addr, 32'h100);
    check("sh_we", cap_we, 1);
    check("sh_stall", stall_c, 3);
    check("sh_reqc", req_c, 3);

    // SB at lane 1
    run(mk(0, 1, 0, 0, 3'b000), 32'h101, 32'h000000AB, 0, 0, 0, 0, 32'h0,
        pk(0, 0, 0, 32'h0));
    check("sb_be", cap_be, 4'b0010);
    check("sb_wdata", cap_wdata, 32'h0000AB00);

    // misaligned accesses
    run(mk(1, 0, 0, 0, F3_LW), 32'h101, 0, 0, 0, 0, 0, 32'h0, pk(0, 1, 0, 32'h0));
    check("mis_lw_stall", stall_c, 0);
    check("mis_lw_reqc", req_c, 0);
    run(mk(1, 0, 0, 0, F3_LH), 32'h103, 0, 0, 0, 0, 0, 32'h0, pk(0, 1, 0, 32'h0));
    check("mis_lh_reqc", req_c, 0);

    // bus timeout
    run(mk(1, 0, 0, 0, F3_LW), 32'h200, 0, 0, 0, 0, 100, 32'h0, pk(0, 0, 1, 32'h0));
    check("to_reqc", req_c, TIMEOUT);
    check("to_stall", stall_c, TIMEOUT + 1);

    // branches and jump
    run(mk(0, 0, 1, 0, F3_BLT), 32'h0, 0, 0, 1, 0, 0, 32'h0, pk(1, 0, 0, 32'h0));
    run(mk(0, 0, 1, 0, F3_BGEU), 32'h0, 0, 0, 0, 1, 0, 32'h0, pk(0, 0, 0, 32'h0));
    run(mk(0, 0, 0, 1, F3_BEQ), 32'h0, 0, 0, 0, 0, 0, 32'h0, pk(1, 0, 0, 32'h0));
    run(mk(0, 0, 1, 0, F3_BNE), 32'h0, 0, 1, 0, 0, 0, 32'h0, pk(0, 0, 0, 32'h0));
    run(mk(0, 0, 1, 0, 3'b010), 32'h0, 0, 1, 1, 1, 0, 32'h0, pk(0, 0, 0, 32'h0));
    run(mk(0, 0, 1, 0, F3_BGE), 32'h0, 0, 0, 0, 0, 0, 32'h0, pk(1, 0, 0, 32'h0));

    // outputs hold while idle
    repeat (2) @(negedge i_clk);
    check("hold_pcsrc", o_PCSrc, 1);
    check("hold_valid", o_valid, 0);

    // reset asserted mid-REQ drops the request at once
    @(posedge i_clk); #1;
    i_ctrlMEM  = mk(1, 0, 0, 0, F3_LW);
    i_addr     = 32'h300;
    i_memReady = 1'b0;
    i_valid    = 1'b1;
    @(posedge i_clk); #1;
    check("mid_req_on", o_memReq, 1);
    @(posedge i_clk); #2;
    i_reset = 1'b1;
    #1;
    check("mid_rst_memreq", o_memReq, 0);
    check("mid_rst_state", o_dbgState, IDLE);
    check("mid_rst_pcsrc", o_PCSrc, 0);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    #1;
    i_reset = 1'b0;

    // normal operation after reset
    run(mk(1, 0, 0, 0, F3_LBU), 32'h102, 0, 0, 0, 0, 0, 32'h00FF0000,
        pk(0, 0, 0, 32'h000000FF));

    repeat (3) @(negedge i_clk);
    check("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
